// File: rtl/toy_fetch_queue.sv
// Toy CPU instruction-fetch front end: one-outstanding memory read FSM feeding
// a show-ahead FIFO of {pc, word} entries, flushed by core redirects.
module toy_fetch_queue #(
   parameter int          DEPTH    = 4,
   parameter logic [11:0] RESET_PC = 12'h010
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        redirect_valid,
   input  logic [11:0] redirect_pc,
   input  logic        halt,
   output logic        mem_req,
   output logic [11:0] mem_addr,
   input  logic        mem_ack,
   input  logic [15:0] mem_rdata,
   output logic        ins_valid,
   output logic [15:0] ins_data,
   output logic [11:0] ins_pc,
   input  logic        ins_ready
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      DISCARD = 2'd2
   } state_t;

   state_t        state_r;
   logic [11:0]   fetch_pc_r;
   logic [15:0]   data_mem_r [DEPTH];
   logic [11:0]   pc_mem_r   [DEPTH];
   logic [AW-1:0] rd_ptr_r;
   logic [AW-1:0] wr_ptr_r;
   logic [CW-1:0] count_r;

   logic          push_s;
   logic          pop_s;
   logic          issue_s;
   logic [CW-1:0] remain_s;
   logic [CW-1:0] count_nxt_s;
   logic [AW-1:0] rd_ptr_nxt_s;
   logic [AW-1:0] wr_ptr_nxt_s;
   logic          head_load_s;
   logic [15:0]   head_data_s;
   logic [11:0]   head_pc_s;

   // FIFO bookkeeping and next head; a redirect overrides both push and pop.
   always_comb begin
      pop_s        = (count_r != {CW{1'b0}}) && ins_ready;
      push_s       = (state_r == REQ) && mem_ack && !redirect_valid;
      issue_s      = (state_r == IDLE) && !halt && !redirect_valid && (count_r < DEPTH_C);
      remain_s     = count_r - CW'(pop_s);
      count_nxt_s  = {CW{1'b0}};
      rd_ptr_nxt_s = {AW{1'b0}};
      wr_ptr_nxt_s = {AW{1'b0}};
      head_load_s  = 1'b0;
      head_data_s  = ins_data;
      head_pc_s    = ins_pc;
      if (redirect_valid) begin
         count_nxt_s  = {CW{1'b0}};
         rd_ptr_nxt_s = {AW{1'b0}};
         wr_ptr_nxt_s = {AW{1'b0}};
      end else begin
         count_nxt_s  = remain_s + CW'(push_s);
         rd_ptr_nxt_s = rd_ptr_r + AW'(pop_s);
         wr_ptr_nxt_s = wr_ptr_r + AW'(push_s);
         // An older entry outranks the word arriving this cycle for the head.
         if (remain_s != {CW{1'b0}}) begin
            head_load_s = 1'b1;
            head_data_s = data_mem_r[rd_ptr_nxt_s];
            head_pc_s   = pc_mem_r[rd_ptr_nxt_s];
         end else if (push_s) begin
            head_load_s = 1'b1;
            head_data_s = mem_rdata;
            head_pc_s   = fetch_pc_r;
         end else begin
            head_load_s = 1'b0;
         end
      end
   end

   // FIFO storage and pointers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_ptr_r <= {AW{1'b0}};
         wr_ptr_r <= {AW{1'b0}};
         count_r  <= {CW{1'b0}};
         for (int i = 0; i < DEPTH; i++) begin
            data_mem_r[i] <= 16'h0000;
            pc_mem_r[i]   <= 12'h000;
         end
      end else begin
         if (push_s) begin
            data_mem_r[wr_ptr_r] <= mem_rdata;
            pc_mem_r[wr_ptr_r]   <= fetch_pc_r;
         end
         rd_ptr_r <= rd_ptr_nxt_s;
         wr_ptr_r <= wr_ptr_nxt_s;
         count_r  <= count_nxt_s;
      end
   end

   // Fetch FSM with registered memory and instruction outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r    <= IDLE;
         fetch_pc_r <= RESET_PC;
         mem_req    <= 1'b0;
         mem_addr   <= 12'h000;
         ins_valid  <= 1'b0;
         ins_data   <= 16'h0000;
         ins_pc     <= 12'h000;
      end else begin
         ins_valid <= (count_nxt_s != {CW{1'b0}});
         if (head_load_s) begin
            ins_data <= head_data_s;
            ins_pc   <= head_pc_s;
         end
         case (state_r)
            IDLE: begin
               if (redirect_valid) begin
                  fetch_pc_r <= redirect_pc;
               end else if (issue_s) begin
                  state_r  <= REQ;
                  mem_req  <= 1'b1;
                  mem_addr <= fetch_pc_r;
               end
            end
            REQ: begin
               if (mem_ack) begin
                  state_r    <= IDLE;
                  mem_req    <= 1'b0;
                  fetch_pc_r <= redirect_valid ? redirect_pc : (fetch_pc_r + 12'd1);
               end else if (redirect_valid) begin
                  // The pending handshake must still finish; its data is dropped.
                  state_r    <= DISCARD;
                  fetch_pc_r <= redirect_pc;
               end
            end
            DISCARD: begin
               if (redirect_valid) begin
                  fetch_pc_r <= redirect_pc;
               end
               if (mem_ack) begin
                  state_r <= IDLE;
                  mem_req <= 1'b0;
               end
            end
            default: begin
               state_r <= IDLE;
               mem_req <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_toy_fetch_queue.sv
// Directed bench for toy_fetch_queue: per-cycle vector table for the basic
// fetch/redirect flow, plus hand sequences for full, wrap, halt and reset cases.
module tb_toy_fetch_queue;

   logic        clk;
   logic        reset;
   logic        redirect_valid;
   logic [11:0] redirect_pc;
   logic        halt;
   logic        mem_req;
   logic [11:0] mem_addr;
   logic        mem_ack;
   logic [15:0] mem_rdata;
   logic        ins_valid;
   logic [15:0] ins_data;
   logic [11:0] ins_pc;
   logic        ins_ready;

   int checks;
   int failures;
   logic [27:0] got_q[$];

   toy_fetch_queue #(.DEPTH(4), .RESET_PC(12'h010)) dut (
      .clk(clk), .reset(reset), .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc), .halt(halt), .mem_req(mem_req),
      .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .ins_valid(ins_valid), .ins_data(ins_data), .ins_pc(ins_pc),
      .ins_ready(ins_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        redir;
      logic [11:0] rpc;
      logic        ack;
      logic [15:0] rdata;
      logic        req;
      logic [11:0] addr;
      logic        vld;
      logic [15:0] d;
      logic [11:0] p;
   } vec_t;

   vec_t vecs[19];

   function automatic logic [15:0] word_of(input logic [11:0] a);
      return {4'hA, a};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One clock; records the word consumed at that edge, returns #1 after it.
   task automatic cycle();
      @(negedge clk);
      if (ins_valid && ins_ready) got_q.push_back({ins_pc, ins_data});
      @(posedge clk);
      #1;
   endtask

   task automatic wait_req(input logic [11:0] exp_addr);
      int n;
      n = 0;
      while (!mem_req && n < 20) begin
         cycle();
         n++;
      end
      chk("req_seen", 32'(mem_req), 32'd1);
      chk("req_addr", 32'(mem_addr), 32'(exp_addr));
   endtask

   task automatic fetch_one(input logic [11:0] exp_addr);
      wait_req(exp_addr);
      mem_ack   = 1'b1;
      mem_rdata = word_of(mem_addr);
      cycle();
      mem_ack   = 1'b0;
   endtask

   task automatic chk_got(input int idx, input logic [11:0] exp_pc);
      logic [27:0] e;
      e = {exp_pc, word_of(exp_pc)};
      if (idx < got_q.size()) chk("popped_word", 32'(got_q[idx]), 32'(e));
      else chk("popped_present", 32'(got_q.size()), 32'(idx + 1));
   endtask

   initial begin
      checks = 0;
      failures = 0;
      reset = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc = 12'h000;
      halt = 1'b0;
      mem_ack = 1'b0;
      mem_rdata = 16'h0000;
      ins_ready = 1'b1;

      vecs[0]  = '{1'b0, 12'h000, 1'b0, 16'h0000, 1'b1, 12'h010, 1'b0, 16'h0000, 12'h000};
      vecs[1]  = '{1'b0, 12'h000, 1'b0, 16'h0000, 1'b1, 12'h010, 1'b0, 16'h0000, 12'h000};
      vecs[2]  = '{1'b0, 12'h000, 1'b1, 16'hA010, 1'b0, 12'h010, 1'b1, 16'hA010, 12'h010};
      vecs[3]  = '{1'b0, 12'h000, 1'b0, 16'h0000, 1'b1, 12'h011, 1'b0, 16'hA010, 12'h010};
      vecs[4]  = '{1'b0, 12'h000, 1'b0, 16'h0000, 1'b1, 12'h011, 1'b0, 16'hA010, 12'h010};
      vecs[5]  = '{1'b0, 12'h000, 1'b1, 16'hA011, 1'b0, 12'h011, 1'b1, 16'hA011, 12'h011};
      vecs[6]  = '{1'b0, 12'h000, 1'b0, 16'h0000, 1'b1, 12'h012, 1'b0, 16'hA011, 12'h011};
      vecs[7]  = '{1'b0, 12'h000, 1'b0, 16'h0000, 1'b1, 12'h012, 1'b0, 16'hA011, 12'h011};
      vecs[8]  = '{1'b0, 12'h000, 1'b1, 16'hA012, 1'b0, 12'h012, 1'b1, 16'hA012, 12'h012};
      vecs[9]  = '{1'b0, 12'h000, 1'b0, 16'h0000, 1'b1, 12'h013, 1'b0, 16'hA012, 12'h012};
      vecs[10] = '{1'b1, 12'h100, 1'b0, 16'h0000, 1'b1, 12'h013, 1'b0, 16'hA012, 12'h012};
      vecs[11] = '{1'b0, 12'h000, 1'b0, 16'h0000, 1'b1, 12'h013, 1'b0, 16'hA012, 12'h012};
      vecs[12] = '{1'b0, 12'h000, 1'b0, 16'h0000, 1'b1, 12'h013, 1'b0, 16'hA012, 12'h012};
      vecs[13] = '{1'b0, 12'h000, 1'b1, 16'hA013, 1'b0, 12'h013, 1'b0, 16'hA012, 12'h012};
      vecs[14] = '{1'b0, 12'h000, 1'b0, 16'h0000, 1'b1, 12'h100, 1'b0, 16'hA012, 12'h012};
      vecs[15] = '{1'b0, 12'h000, 1'b1, 16'hA100, 1'b0, 12'h100, 1'b1, 16'hA100, 12'h100};
      vecs[16] = '{1'b0, 12'h000, 1'b0, 16'h0000, 1'b1, 12'h101, 1'b0, 16'hA100, 12'h100};
      vecs[17] = '{1'b1, 12'hFFE, 1'b0, 16'h0000, 1'b1, 12'h101, 1'b0, 16'hA100, 12'h100};
      vecs[18] = '{1'b0, 12'h000, 1'b1, 16'hDEAD, 1'b0, 12'h101, 1'b0, 16'hA100, 12'h100};

      repeat (2) cycle();
      chk("rst_mem_req", 32'(mem_req), 32'd0);
      chk("rst_mem_addr", 32'(mem_addr), 32'd0);
      chk("rst_ins_valid", 32'(ins_valid), 32'd0);
      chk("rst_ins_data", 32'(ins_data), 32'd0);
      chk("rst_ins_pc", 32'(ins_pc), 32'd0);
      reset = 1'b1;

      // Basic fetch stream, then redirect during a waiting request.
      for (int i = 0; i < 19; i++) begin
         redirect_valid = vecs[i].redir;
         redirect_pc    = vecs[i].rpc;
         mem_ack        = vecs[i].ack;
         mem_rdata      = vecs[i].rdata;
         cycle();
         chk($sformatf("v%0d_mem_req", i), 32'(mem_req), 32'(vecs[i].req));
         chk($sformatf("v%0d_mem_addr", i), 32'(mem_addr), 32'(vecs[i].addr));
         chk($sformatf("v%0d_ins_valid", i), 32'(ins_valid), 32'(vecs[i].vld));
         chk($sformatf("v%0d_ins_data", i), 32'(ins_data), 32'(vecs[i].d));
         chk($sformatf("v%0d_ins_pc", i), 32'(ins_pc), 32'(vecs[i].p));
      end
      redirect_valid = 1'b0;
      mem_ack = 1'b0;

      // PC wrap after redirect to 0xFFE.
      got_q.delete();
      fetch_one(12'hFFE);
      fetch_one(12'hFFF);
      fetch_one(12'h000);
      fetch_one(12'h001);
      repeat (3) cycle();
      chk("wrap_count", 32'(got_q.size()), 32'd4);
      chk_got(0, 12'hFFE);
      chk_got(1, 12'hFFF);
      chk_got(2, 12'h000);
      chk_got(3, 12'h001);

      // Fill to DEPTH with consumer stalled, then drain.
      ins_ready = 1'b0;
      got_q.delete();
      fetch_one(12'h002);
      fetch_one(12'h003);
      fetch_one(12'h004);
      fetch_one(12'h005);
      for (int i = 0; i < 6; i++) begin
         chk("full_no_req", 32'(mem_req), 32'd0);
         cycle();
      end
      chk("full_valid", 32'(ins_valid), 32'd1);
      chk("full_head_pc", 32'(ins_pc), 32'h002);
      ins_ready = 1'b1;
      repeat (6) cycle();
      chk("drain_count", 32'(got_q.size()), 32'd4);
      for (int i = 0; i < 4; i++) chk_got(i, 12'(12'h002 + i));
      fetch_one(12'h006);
      cycle();

      // Halt lets the outstanding request complete, then blocks issue.
      ins_ready = 1'b0;
      wait_req(12'h007);
      halt = 1'b1;
      repeat (2) cycle();
      chk("halt_hold_req", 32'(mem_req), 32'd1);
      chk("halt_hold_addr", 32'(mem_addr), 32'h007);
      mem_ack = 1'b1;
      mem_rdata = word_of(12'h007);
      cycle();
      mem_ack = 1'b0;
      chk("halt_word_valid", 32'(ins_valid), 32'd1);
      chk("halt_word_pc", 32'(ins_pc), 32'h007);
      chk("halt_word_data", 32'(ins_data), 32'hA007);
      for (int i = 0; i < 5; i++) begin
         cycle();
         chk("halt_no_req", 32'(mem_req), 32'd0);
      end
      halt = 1'b0;
      wait_req(12'h008);

      // Redirect, pop and ack in the same cycle: flush wins.
      redirect_valid = 1'b1;
      redirect_pc = 12'h200;
      ins_ready = 1'b1;
      mem_ack = 1'b1;
      mem_rdata = word_of(12'h008);
      cycle();
      redirect_valid = 1'b0;
      mem_ack = 1'b0;
      ins_ready = 1'b0;
      chk("flush_valid", 32'(ins_valid), 32'd0);
      chk("flush_req", 32'(mem_req), 32'd0);
      cycle();
      chk("flush_still_empty", 32'(ins_valid), 32'd0);
      wait_req(12'h200);

      // Reset asserted mid-request with two words queued.
      fetch_one(12'h200);
      fetch_one(12'h201);
      wait_req(12'h202);
      chk("pre_rst_valid", 32'(ins_valid), 32'd1);
      #2;
      reset = 1'b0;
      #1;
      chk("async_rst_req", 32'(mem_req), 32'd0);
      chk("async_rst_valid", 32'(ins_valid), 32'd0);
      chk("async_rst_addr", 32'(mem_addr), 32'd0);
      chk("async_rst_pc", 32'(ins_pc), 32'd0);
      repeat (2) cycle();
      reset = 1'b1;
      wait_req(12'h010);
      chk("post_rst_valid", 32'(ins_valid), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
